// File: rtl/hazard_unit_mc.sv
// Sequential pipeline hazard controller: load-use, redirect, multi-cycle EX ops and dmem wait.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit_mc #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned MC_LATENCY  = 34,
   parameter int unsigned MC_USE_DONE = 0,
   parameter int unsigned PERF_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_memread,
   input  logic                  ex_mc_valid,
   input  logic                  mc_done,
   input  logic                  pc_redirect,
   input  logic                  mem_req,
   input  logic                  dmem_ready,
   output logic                  pc_write_enable,
   output logic                  if_id_write_enable,
   output logic                  id_ex_write_enable,
   output logic                  ex_mem_write_enable,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  flush_ex_mem,
   output logic                  mc_start,
   output logic [PERF_W-1:0]     perf_load_use,
   output logic [PERF_W-1:0]     perf_mc,
   output logic [PERF_W-1:0]     perf_mem,
   output logic [PERF_W-1:0]     perf_flush
);

   localparam int unsigned CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LATENCY - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] MC_BUSY  = 2'd1;
   localparam logic [1:0] MC_DONE  = 2'd2;
   localparam logic [1:0] MEM_WAIT = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             retired_q, retired_d;
   logic             mem_wait;
   logic             lu;
   logic             allow_mc;
   logic             lu_stall;
   logic             flush_taken;

   assign mem_wait = mem_req & ~dmem_ready;
   assign lu = ex_memread && (ex_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         retired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         retired_q <= retired_d;
      end
   end

   // Next state and pipeline controls
   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      done_d              = done_q;
      retired_d           = retired_q;
      allow_mc            = 1'b0;
      pc_write_enable     = 1'b1;
      if_id_write_enable  = 1'b1;
      id_ex_write_enable  = 1'b1;
      ex_mem_write_enable = 1'b1;
      flush_if_id         = 1'b0;
      flush_id_ex         = 1'b0;
      flush_ex_mem        = 1'b0;
      mc_start            = 1'b0;
      lu_stall            = 1'b0;
      flush_taken         = 1'b0;

      if (!rst) begin
         case (state_q)
            MC_BUSY: begin
               pc_write_enable    = 1'b0;
               if_id_write_enable = 1'b0;
               id_ex_write_enable = 1'b0;
               if (mem_wait) ex_mem_write_enable = 1'b0;
               else          flush_ex_mem        = 1'b1;
               // The op timer keeps running under a memory wait; only the exit waits for MEM.
               if (MC_USE_DONE != 0) begin
                  done_d = done_q | mc_done;
                  if ((done_q || mc_done) && !mem_wait) begin
                     state_d = MC_DONE;
                     done_d  = 1'b0;
                  end
               end else begin
                  cnt_d = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
                  if ((cnt_q <= CNT_ONE) && !mem_wait) state_d = MC_DONE;
               end
            end
            default: begin
               // A completed op frozen in EX by a wait must not be relaunched on release.
               allow_mc = (state_q == IDLE) || ((state_q == MEM_WAIT) && !retired_q);
               if (mem_wait) begin
                  pc_write_enable     = 1'b0;
                  if_id_write_enable  = 1'b0;
                  id_ex_write_enable  = 1'b0;
                  ex_mem_write_enable = 1'b0;
                  state_d             = MEM_WAIT;
                  retired_d           = retired_q | (state_q == MC_DONE);
               end else begin
                  state_d   = IDLE;
                  retired_d = 1'b0;
                  if (ex_mc_valid && allow_mc) begin
                     mc_start           = 1'b1;
                     pc_write_enable    = 1'b0;
                     if_id_write_enable = 1'b0;
                     id_ex_write_enable = 1'b0;
                     flush_ex_mem       = 1'b1;
                     cnt_d              = CNT_INIT;
                     done_d             = 1'b0;
                     state_d = ((MC_USE_DONE == 0) && (MC_LATENCY <= 2)) ? MC_DONE : MC_BUSY;
                  end else if (pc_redirect) begin
                     flush_if_id = 1'b1;
                     flush_id_ex = 1'b1;
                     flush_taken = 1'b1;
                  end else if (lu) begin
                     pc_write_enable    = 1'b0;
                     if_id_write_enable = 1'b0;
                     flush_id_ex        = 1'b1;
                     lu_stall           = 1'b1;
                  end
               end
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating event counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_load_use <= '0;
         perf_mc       <= '0;
         perf_mem      <= '0;
         perf_flush    <= '0;
      end else begin
         if (lu_stall && !(&perf_load_use)) perf_load_use <= perf_load_use + PERF_W'(1);
         if (((state_q == MC_BUSY) || mc_start) && !(&perf_mc)) perf_mc <= perf_mc + PERF_W'(1);
         if (mem_wait && !(&perf_mem)) perf_mem <= perf_mem + PERF_W'(1);
         if (flush_taken && !(&perf_flush)) perf_flush <= perf_flush + PERF_W'(1);
      end
   end
`else
   logic unused_perf;
   assign unused_perf   = lu_stall ^ flush_taken;
   assign perf_load_use = '0;
   assign perf_mc       = '0;
   assign perf_mem      = '0;
   assign perf_flush    = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: fixed-latency and handshake instances share most inputs.
module tb_hazard_unit_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_memread;
   logic       mc_valid_fix, mc_valid_done, mc_done;
   logic       pc_redirect, mem_req, dmem_ready;

   logic fx_pc_we, fx_ifid_we, fx_idex_we, fx_exmem_we, fx_fl_ifid, fx_fl_idex, fx_fl_exmem, fx_mc_start;
   logic dn_pc_we, dn_ifid_we, dn_idex_we, dn_exmem_we, dn_fl_ifid, dn_fl_idex, dn_fl_exmem, dn_mc_start;
   logic [31:0] fx_perf_lu, fx_perf_mc, fx_perf_mem, fx_perf_flush;
   logic [31:0] dn_perf_lu, dn_perf_mc, dn_perf_mem, dn_perf_flush;

   logic [7:0] fx_out, dn_out;
   assign fx_out = {fx_pc_we, fx_ifid_we, fx_idex_we, fx_exmem_we, fx_fl_ifid, fx_fl_idex, fx_fl_exmem, fx_mc_start};
   assign dn_out = {dn_pc_we, dn_ifid_we, dn_idex_we, dn_exmem_we, dn_fl_ifid, dn_fl_idex, dn_fl_exmem, dn_mc_start};

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   // {pc, if_id, id_ex, ex_mem enables, flush if_id, id_ex, ex_mem, mc_start}
   localparam logic [7:0] O_RUN   = 8'hF0;
   localparam logic [7:0] O_LU    = 8'h34;
   localparam logic [7:0] O_REDIR = 8'hFC;
   localparam logic [7:0] O_FROZE = 8'h00;
   localparam logic [7:0] O_START = 8'h13;
   localparam logic [7:0] O_BUSY  = 8'h12;

   hazard_unit_mc #(.REG_ADDR_W(5), .MC_LATENCY(4), .MC_USE_DONE(0), .PERF_W(32)) dut_fix (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_mc_valid(mc_valid_fix), .mc_done(mc_done),
      .pc_redirect(pc_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_write_enable(fx_pc_we), .if_id_write_enable(fx_ifid_we),
      .id_ex_write_enable(fx_idex_we), .ex_mem_write_enable(fx_exmem_we),
      .flush_if_id(fx_fl_ifid), .flush_id_ex(fx_fl_idex), .flush_ex_mem(fx_fl_exmem),
      .mc_start(fx_mc_start), .perf_load_use(fx_perf_lu), .perf_mc(fx_perf_mc),
      .perf_mem(fx_perf_mem), .perf_flush(fx_perf_flush)
   );

   hazard_unit_mc #(.REG_ADDR_W(5), .MC_LATENCY(4), .MC_USE_DONE(1), .PERF_W(32)) dut_done (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_mc_valid(mc_valid_done), .mc_done(mc_done),
      .pc_redirect(pc_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_write_enable(dn_pc_we), .if_id_write_enable(dn_ifid_we),
      .id_ex_write_enable(dn_idex_we), .ex_mem_write_enable(dn_exmem_we),
      .flush_if_id(dn_fl_ifid), .flush_id_ex(dn_fl_idex), .flush_ex_mem(dn_fl_exmem),
      .mc_start(dn_mc_start), .perf_load_use(dn_perf_lu), .perf_mc(dn_perf_mc),
      .perf_mem(dn_perf_mem), .perf_flush(dn_perf_flush)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
      mc_valid_fix = 1'b0; mc_valid_done = 1'b0; mc_done = 1'b0;
      pc_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, redir, mreq, mrdy;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      //            rs1   rs2   rd    u1 u2 mr rd mq my exp
      vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, O_RUN};
      vecs[1]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 1, O_LU};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 1, O_RUN};
      vecs[3]  = '{5'd7, 5'd0, 5'd7, 1, 0, 1, 0, 0, 1, O_LU};
      vecs[4]  = '{5'd7, 5'd0, 5'd7, 0, 0, 1, 0, 0, 1, O_RUN};
      vecs[5]  = '{5'd0, 5'd5, 5'd5, 0, 1, 0, 0, 0, 1, O_RUN};
      vecs[6]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 0, 1, O_REDIR};
      vecs[7]  = '{5'd3, 5'd0, 5'd9, 1, 0, 0, 1, 0, 1, O_REDIR};
      vecs[8]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 1, 1, O_LU};
      vecs[9]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 1, 0, O_FROZE};
      vecs[10] = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 1, 1, O_REDIR};
      vecs[11] = '{5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 1, O_RUN};

      set_idle();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("reset_fix_out", 32'(fx_out), 32'(O_RUN));
      check("reset_done_out", 32'(dn_out), 32'(O_RUN));
      check("reset_perf_lu", fx_perf_lu, 32'd0);
      check("reset_perf_flush", fx_perf_flush, 32'd0);

      // Single-cycle vectors from the unfrozen state
      for (int i = 0; i < 12; i++) begin
         cyc();
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; ex_memread = vecs[i].mr;
         pc_redirect = vecs[i].redir; mem_req = vecs[i].mreq; dmem_ready = vecs[i].mrdy;
         @(negedge clk);
         check($sformatf("vec%0d_fix", i), 32'(fx_out), 32'(vecs[i].exp));
         check($sformatf("vec%0d_done", i), 32'(dn_out), 32'(vecs[i].exp));
      end
      cyc();
      set_idle();
      @(negedge clk);
      check("table_perf_lu", fx_perf_lu, PERF_ON ? 32'd3 : 32'd0);
      check("table_perf_flush", fx_perf_flush, PERF_ON ? 32'd3 : 32'd0);
      check("table_perf_mem", fx_perf_mem, PERF_ON ? 32'd1 : 32'd0);
      check("table_perf_mc", fx_perf_mc, 32'd0);

      // Multi-cycle op: fixed latency 4 vs. mc_done handshake on cycle 7
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int c = 0; c <= 8; c++) begin
         cyc();
         mc_valid_fix  = (c <= 3);
         mc_valid_done = 1'b1;
         mc_done       = (c == 7);
         @(negedge clk);
         check($sformatf("mc_fix_c%0d", c), 32'(fx_out),
               32'((c == 0) ? O_START : (c <= 2) ? O_BUSY : O_RUN));
         check($sformatf("mc_done_c%0d", c), 32'(dn_out),
               32'((c == 0) ? O_START : (c <= 7) ? O_BUSY : O_RUN));
      end
      cyc();
      set_idle();
      @(negedge clk);
      check("mc_perf_fix", fx_perf_mc, PERF_ON ? 32'd3 : 32'd0);
      check("mc_perf_done", dn_perf_mc, PERF_ON ? 32'd8 : 32'd0);

      // Memory wait for three cycles, released by dmem_ready
      for (int c = 0; c <= 4; c++) begin
         cyc();
         mem_req    = (c <= 3);
         dmem_ready = (c == 3);
         @(negedge clk);
         check($sformatf("memw_fix_c%0d", c), 32'(fx_out), 32'((c <= 2) ? O_FROZE : O_RUN));
         check($sformatf("memw_done_c%0d", c), 32'(dn_out), 32'((c <= 2) ? O_FROZE : O_RUN));
      end

      // Redirect held across an MC op with a memory wait inside MC_BUSY
      for (int c = 0; c <= 4; c++) begin
         cyc();
         mc_valid_fix = (c <= 3);
         pc_redirect  = (c <= 3);
         mem_req      = (c == 1);
         dmem_ready   = (c != 1);
         @(negedge clk);
         check($sformatf("mcw_fix_c%0d", c), 32'(fx_out),
               32'((c == 0) ? O_START : (c == 1) ? O_FROZE : (c == 2) ? O_BUSY :
                   (c == 3) ? O_REDIR : O_RUN));
         check($sformatf("mcw_done_c%0d", c), 32'(dn_out),
               32'((c == 1) ? O_FROZE : (c <= 3) ? O_REDIR : O_RUN));
      end
      cyc();
      set_idle();

      // Reset in the middle of MC_BUSY, then a fresh op
      for (int c = 0; c <= 6; c++) begin
         cyc();
         rst          = (c == 1);
         mc_valid_fix = (c <= 1) || (c >= 3 && c <= 5);
         @(negedge clk);
         check($sformatf("rstmc_fix_c%0d", c), 32'(fx_out),
               32'((c == 0 || c == 3) ? O_START : (c == 4 || c == 5) ? O_BUSY : O_RUN));
         if (c == 1) check("rstmc_done_c1", 32'(dn_out), 32'(O_RUN));
         if (c == 2) begin
            check("rstmc_perf_lu", fx_perf_lu, 32'd0);
            check("rstmc_perf_mc", fx_perf_mc, 32'd0);
            check("rstmc_perf_mem", fx_perf_mem, 32'd0);
            check("rstmc_perf_flush", fx_perf_flush, 32'd0);
            check("rstmc_dn_perf", dn_perf_lu | dn_perf_mc | dn_perf_mem | dn_perf_flush, 32'd0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
